// File: rtl/seq_window_detector.sv
// Serial detector for a masked PAT_W-bit pattern anywhere in the last WIN accepted bits.
// Optional hit counter is built only when SEQDET_COUNT_EN is defined.
module seq_window_detector #(
   parameter int               PAT_W   = 3,
   parameter int               WIN     = 4,
   parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             x,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [PAT_W-1:0] cfg_mask,
   input  logic             cfg_nonovl,
   input  logic             count_clr,
   output logic             y,
   output logic             hit,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int FW = $clog2(WIN + 1);
   localparam int GW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FILL_MAX  = FW'(WIN);
   localparam logic [GW-1:0] GUARD_MAX = GW'(PAT_W);

   logic [WIN-1:0]   sh;
   logic [FW-1:0]    fill;
   logic [GW-1:0]    guard;
   logic [PAT_W-1:0] pat;
   logic [PAT_W-1:0] mask;
   logic             nonovl;

   logic [WIN-1:0]   sh_next;
   logic [FW-1:0]    fill_next;
   logic [GW-1:0]    guard_next;
   logic             any_next;
   logic             match0_next;
   logic             hit_next;

   function automatic logic [FW-1:0] sat_fill(input logic [FW-1:0] v);
      return (v >= FILL_MAX) ? v : v + FW'(1);
   endfunction

   function automatic logic [GW-1:0] sat_guard(input logic [GW-1:0] v);
      return (v >= GUARD_MAX) ? v : v + GW'(1);
   endfunction

   // An offset only counts once enough samples have arrived to fill it completely.
   function automatic logic offset_match(input logic [WIN-1:0] s, input logic [FW-1:0] f,
                                         input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                                         input int k);
      logic [PAT_W-1:0] seg;
      seg = PAT_W'(s >> k);
      return (m != '0) && ((seg & m) == (p & m)) && (int'(f) >= k + PAT_W);
   endfunction

   always_comb begin
      sh_next     = sh << 1;
      sh_next[0]  = x;
      fill_next   = sat_fill(fill);
      guard_next  = sat_guard(guard);
      any_next    = 1'b0;
      match0_next = 1'b0;
      for (int k = 0; k <= WIN - PAT_W; k++) begin
         if (offset_match(sh_next, fill_next, pat, mask, k)) begin
            any_next = 1'b1;
            if (k == 0) match0_next = 1'b1;
         end
      end
      hit_next = match0_next && (int'(fill_next) >= PAT_W) &&
                 (!nonovl || (guard_next >= GUARD_MAX));
   end

   // Config writes win over a same-cycle sample and restart the window from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh     <= '0;
         fill   <= '0;
         guard  <= GUARD_MAX;
         pat    <= PAT_RST;
         mask   <= '1;
         nonovl <= 1'b0;
         y      <= 1'b0;
         hit    <= 1'b0;
      end else if (cfg_we) begin
         pat    <= cfg_pattern;
         mask   <= cfg_mask;
         nonovl <= cfg_nonovl;
         sh     <= '0;
         fill   <= '0;
         guard  <= GUARD_MAX;
         y      <= 1'b0;
         hit    <= 1'b0;
      end else if (in_valid) begin
         sh     <= sh_next;
         fill   <= fill_next;
         guard  <= hit_next ? '0 : guard_next;
         y      <= any_next;
         hit    <= hit_next;
      end else begin
         hit    <= 1'b0;
      end
   end

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] count;
   logic             count_hit;

   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign count_hit = in_valid && !cfg_we && hit_next;

   always_ff @(posedge clk) begin
      if (rst || count_clr) count <= '0;
      else if (count_hit)   count <= sat_count(count);
   end

   assign match_count = count;
   assign count_sat   = (count == '1);
`else
   logic unused_count_clr;
   assign unused_count_clr = count_clr;
   assign match_count      = '0;
   assign count_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_window_detector.sv
// Self-checking bench for seq_window_detector: table-driven streams plus corner-case sequences.
module tb_seq_window_detector;

`ifdef SEQDET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1, in_valid = 1'b0, x = 1'b0, cfg_we = 1'b0;
   logic       cfg_nonovl = 1'b0, count_clr = 1'b0;
   logic [2:0] cfg_pattern = 3'b101, cfg_mask = 3'b111;
   logic       y0, hit0, sat0, y1, hit1, sat1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   always #5 clk = ~clk;

   seq_window_detector #(.PAT_W(3), .WIN(4), .PAT_RST(3'b101), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_nonovl(cfg_nonovl),
      .count_clr(count_clr), .y(y0), .hit(hit0), .match_count(cnt0), .count_sat(sat0));

   seq_window_detector #(.PAT_W(3), .WIN(4), .PAT_RST(3'b101), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_nonovl(cfg_nonovl),
      .count_clr(count_clr), .y(y1), .hit(hit1), .match_count(cnt1), .count_sat(sat1));

   typedef struct {
      logic  y;
      logic  hit;
      int    c0;
      logic  s0;
      int    c1;
      logic  s1;
      string tag;
   } exp_t;

   typedef struct {
      logic x;
      logic y;
      logic hit_ovl;
      logic hit_nov;
   } vec_t;

   exp_t sb[$];
   vec_t vt[13];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   mc0    = 0;
   int   mc1    = 0;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic xi, input logic we,
                       input logic clr, input logic ey, input logic eh, input string tag);
      exp_t e;
      rst = r; in_valid = v; x = xi; cfg_we = we; count_clr = clr;
      if (r || clr) begin
         mc0 = 0; mc1 = 0;
      end else if (eh) begin
         if (mc0 < 255) mc0++;
         if (mc1 < 3)   mc1++;
      end
      e.y   = ey;
      e.hit = eh;
      e.c0  = CNT_EN ? mc0 : 0;
      e.s0  = CNT_EN && (mc0 == 255);
      e.c1  = CNT_EN ? mc1 : 0;
      e.s1  = CNT_EN && (mc1 == 3);
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, " y"},       int'(y0),   int'(e.y));
      chk({e.tag, " hit"},     int'(hit0), int'(e.hit));
      chk({e.tag, " count"},   int'(cnt0), e.c0);
      chk({e.tag, " sat"},     int'(sat0), int'(e.s0));
      chk({e.tag, " y_b"},     int'(y1),   int'(e.y));
      chk({e.tag, " hit_b"},   int'(hit1), int'(e.hit));
      chk({e.tag, " count_b"}, int'(cnt1), e.c1);
      chk({e.tag, " sat_b"},   int'(sat1), int'(e.s1));
      rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; count_clr = 1'b0;
   endtask

   task automatic cfg(input logic [2:0] p, input logic [2:0] m, input logic n,
                      input logic v, input logic xi, input string tag);
      cfg_pattern = p; cfg_mask = m; cfg_nonovl = n;
      step(1'b0, v, xi, 1'b1, 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      logic [12:0] sx, sy, sho, shn;
      sx  = 13'b0101001101010;
      sy  = 13'b0001100001111;
      sho = 13'b0001000001010;
      shn = 13'b0001000001000;
      for (int i = 0; i < 13; i++) begin
         vt[i].x       = sx[12-i];
         vt[i].y       = sy[12-i];
         vt[i].hit_ovl = sho[12-i];
         vt[i].hit_nov = shn[12-i];
      end

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

      // Default pattern, overlapping hits.
      for (int i = 0; i < 13; i++)
         step(1'b0, 1'b1, vt[i].x, 1'b0, 1'b0, vt[i].y, vt[i].hit_ovl, $sformatf("ovl[%0d]", i));

      // Config while y=1 with a same-cycle sample that must be dropped.
      cfg(3'b101, 3'b111, 1'b1, 1'b1, 1'b1, "cfg_nonovl");
      for (int i = 0; i < 13; i++)
         step(1'b0, 1'b1, vt[i].x, 1'b0, 1'b0, vt[i].y, vt[i].hit_nov, $sformatf("nov[%0d]", i));

      // Don't-care middle bit, then all-zero mask.
      cfg(3'b101, 3'b101, 1'b0, 1'b0, 1'b0, "cfg_mask101");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "m101[0]");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "m101[1]");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "m101[2]");
      cfg(3'b101, 3'b000, 1'b0, 1'b0, 1'b0, "cfg_mask000");
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b1, vt[i].x ^ (i == 0), 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("m000[%0d]", i));

      // Idle gaps do not age the window.
      cfg(3'b101, 3'b111, 1'b0, 1'b0, 1'b0, "cfg_gap");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap_s0");
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("gap_a[%0d]", i));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_s1");
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("gap_b[%0d]", i));
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "gap_s2");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("gap_hold[%0d]", i));

      // Reset mid-stream restores the default pattern.
      cfg(3'b011, 3'b111, 1'b0, 1'b0, 1'b0, "cfg_011");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p011[0]");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "p011[1]");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "p011[2]");
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst[0]");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst[1]");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst[2]");

      // Six hits saturate the narrow counter; then clear coincident with a hit.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_cnt");
      for (int i = 0; i < 13; i++)
         step(1'b0, 1'b1, logic'(i % 2 == 0), 1'b0, 1'b0, logic'(i >= 2),
              logic'(i >= 2 && i % 2 == 0), $sformatf("sat[%0d]", i));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_clr");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "clr_hit");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_clr");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
